// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package wb_arb_pkg;

    localparam int unsigned WB_DATA_W = 8;
    localparam int unsigned WB_ADDR_W = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_G0,
        S_G1
    } wb_state_t;

    localparam logic SEL_ALU = 1'b0;
    localparam logic SEL_LSU = 1'b1;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request/grant bus: two valid/ready sources in, one registered write port out.
interface regfile_wb_arbiter_if #(
    parameter int unsigned DATA_W = wb_arb_pkg::WB_DATA_W,
    parameter int unsigned ADDR_W = wb_arb_pkg::WB_ADDR_W
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              mux_sel;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              starved;

    modport master (
        output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready, mux_sel, wb_en, wb_addr, wb_data, starved
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready, mux_sel, wb_en, wb_addr, wb_data, starved
    );
endinterface

// File: rtl/regfile_wb_arbiter_mux2.sv
// Parameterized-width 2:1 mux for the writeback {addr, data} path.
module wb_mux2 #(
    parameter int unsigned W = 11
) (
    input  logic         sel_i,
    input  logic [W-1:0] in0_i,
    input  logic [W-1:0] in1_i,
    output logic [W-1:0] out_o
);
    assign out_o = sel_i ? in1_i : in0_i;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-port register-file writeback arbiter; fixed priority with port-1 anti-starvation,
// or round-robin when WB_RR_EN is defined.
module regfile_wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned DATA_W       = WB_DATA_W,
    parameter int unsigned ADDR_W       = WB_ADDR_W,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    regfile_wb_arbiter_if.slave bus
);
    wb_state_t                state_q, state_d;
    logic                     sel_hold_q;
    logic                     gnt0, gnt1, mux_sel;
    logic                     wb_en_q;
    logic [ADDR_W-1:0]        wb_addr_q;
    logic [DATA_W-1:0]        wb_data_q;
    logic [ADDR_W+DATA_W-1:0] mux_out;

`ifdef WB_RR_EN
    // Contention goes to the port opposite the previous grant; port 0 wins out of idle.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            if (bus.req0_valid && bus.req1_valid) begin
                if (state_q == S_G0) gnt1 = 1'b1;
                else                 gnt0 = 1'b1;
            end else begin
                gnt0 = bus.req0_valid;
                gnt1 = bus.req1_valid;
            end
        end
    end

    assign bus.starved = 1'b0;
`else
    localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       at_limit;

    always_comb begin
        at_limit     = (starve_cnt_q == Limit);
        gnt1         = rst_n && bus.req1_valid && (!bus.req0_valid || at_limit);
        gnt0         = rst_n && bus.req0_valid && !gnt1;
        starve_cnt_d = '0;
        if (bus.req1_valid && !gnt1) begin
            starve_cnt_d = at_limit ? starve_cnt_q : starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) starve_cnt_q <= '0;
        else        starve_cnt_q <= starve_cnt_d;
    end

    assign bus.starved = (starve_cnt_q != '0);
`endif

    always_comb begin
        state_d = S_IDLE;
        if (gnt0)      state_d = S_G0;
        else if (gnt1) state_d = S_G1;
    end

    // Idle cycles keep the select on the last grant to avoid toggling the mux.
    always_comb begin
        if (gnt1)                  mux_sel = SEL_LSU;
        else if (gnt0)             mux_sel = SEL_ALU;
        else if (state_q == S_G1)  mux_sel = SEL_LSU;
        else if (state_q == S_G0)  mux_sel = SEL_ALU;
        else                       mux_sel = sel_hold_q;
    end

    wb_mux2 #(
        .W(ADDR_W + DATA_W)
    ) u_mux (
        .sel_i(mux_sel),
        .in0_i({bus.req0_addr, bus.req0_data}),
        .in1_i({bus.req1_addr, bus.req1_data}),
        .out_o(mux_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sel_hold_q <= SEL_ALU;
            wb_en_q    <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q <= state_d;
            wb_en_q <= gnt0 || gnt1;
            if (state_q != S_IDLE) sel_hold_q <= (state_q == S_G1);
            if (gnt0 || gnt1) {wb_addr_q, wb_data_q} <= mux_out;
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.mux_sel    = mux_sel;
    assign bus.wb_en      = wb_en_q;
    assign bus.wb_addr    = wb_addr_q;
    assign bus.wb_data    = wb_data_q;
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single register-file write port of the 8-bit pipelined core between two writeback sources: the ALU result path (port 0) and the load/memory path (port 1). Each cycle it arbitrates the valid requests, drives the select of the writeback 2:1 data mux, and registers the winning address and data onto the write port. A losing request is held by its source under a valid/ready handshake. Anti-starvation logic guarantees the load path forward progress.

## Interface
- `DATA_W`, 8: register data width.
- `ADDR_W`, 3: register address width (8 registers).
- `STARVE_LIMIT`, 3: consecutive lost cycles on port 1 before port 1 is forced to win (1..15).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: ALU writeback request.
- `req0_addr` in ADDR_W: ALU destination register.
- `req0_data` in DATA_W: ALU result.
- `req0_ready` out 1: port 0 granted this cycle.
- `req1_valid` in 1: load writeback request.
- `req1_addr` in ADDR_W: load destination register.
- `req1_data` in DATA_W: load data.
- `req1_ready` out 1: port 1 granted this cycle.
- `mux_sel` out 1: writeback mux select. 0 selects ALU, 1 selects load. Combinational and equal to the current grant.
- `wb_en` out 1: register-file write enable (registered).
- `wb_addr` out ADDR_W: write address (registered).
- `wb_data` out DATA_W: write data (registered).
- `starved` out 1: high while the port 1 loss counter is nonzero.

## Operation
- A handshake completes when `reqN_valid && reqN_ready`. Ready is a function of the valid inputs and state only; it never depends on data.
- At most one ready is high per cycle. A ready is never high without its own valid.
- FSM states are `S_IDLE`, `S_G0` and `S_G1`, giving the grant of the previous cycle.
  - No valid: next state is `S_IDLE`.
  - Grant 0: next state is `S_G0`.
  - Grant 1: next state is `S_G1`.
- Default policy (macro absent):
  - Port 0 has priority.
  - `starve_cnt` increments while `req1_valid && !req1_ready`, saturating at `STARVE_LIMIT`.
  - `starve_cnt` clears when port 1 is granted or `req1_valid` is low.
  - When `starve_cnt == STARVE_LIMIT` and both ports are valid, port 1 wins.
- Same-address collision (both valid, same addr): normal arbitration applies. The loser writes in a later cycle, so the later write wins in the register file.
- The winning addr/data go through the mux and are registered. `wb_en` follows the handshake by one cycle.
- Sources must hold valid, addr and data stable until ready; the bench flags any violation.

## Timing
- Reset values:
  - `wb_en`=0, `wb_addr`=0, `wb_data`=0.
  - `mux_sel`=0, `starved`=0, `req0_ready`=`req1_ready`=0.
  - State `S_IDLE`, `starve_cnt`=0.
- Latency: handshake at edge N produces `wb_en`=1 with its addr/data during cycle N+1, for exactly one cycle per handshake.
- Throughput: one write per cycle, with no bubble between consecutive grants.
- With no handshake, `wb_en`=0 and `wb_addr`/`wb_data` hold their previous values.
- Reset asserted mid-operation: all outputs clear immediately (asynchronous). Any pending or in-flight write is dropped, and the first grant comes on the first edge after `rst_n` rises.
- `mux_sel` holds its last grant when idle, to avoid needless toggling.

## Configuration
- `WB_RR_EN` defined: round-robin arbitration.
  - On contention, grant the port opposite to the last grant.
  - From `S_IDLE`, port 0 wins.
  - `starve_cnt` logic is not built, and `starved` is tied to 0.
- `WB_RR_EN` undefined: fixed priority plus starvation counter, as in Operation.

## Structure
- Package `wb_arb_pkg`:
  - `DATA_W`/`ADDR_W` defaults.
  - `wb_state_t` enum (`S_IDLE`, `S_G0`, `S_G1`).
  - `SEL_ALU`=0, `SEL_LSU`=1 constants.
- One sub-module, `wb_mux2`: a parameterized-width 2:1 mux that selects {addr, data} using `mux_sel`.
- The FSM, counter and output register stay in the top module.

## Test plan
- Reset mid-stream: assert `rst_n`=0 while `wb_en`=1 → all outputs are 0 asynchronously. After release, the first request writes one cycle after its grant.
- Port 0 only: valid with addr=3, data=0x5A → `req0_ready`=1, `mux_sel`=0. Next cycle `wb_en`=1, `wb_addr`=3, `wb_data`=0x5A.
- Port 1 only: addr=7, data=0xC3 → `mux_sel`=1. Next cycle the write lands at r7=0xC3, and `starved` stays 0.
- Both ports continuously valid, default build, `STARVE_LIMIT`=3 → port 0 wins 3 cycles, port 1 wins on the 4th, `starved` is high for cycles 2–4, then the pattern repeats.
- Both ports valid with addr=2 (port 0 data 0x11, port 1 data 0x22) → writes 0x11 then 0x22 on consecutive cycles; final r2=0x22.
- `WB_RR_EN` build, both ports continuously valid → grants alternate 0,1,0,1 and `starved` is always 0.
